// File: rtl/comparator_fault_sequencer_if.sv
// Comparator bank / fault sequencer signal bundle.
// Optional field retry_count exists only when
// COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN is defined.
interface comparator_fault_sequencer_if #(
    parameter int N_CHANNELS = 4,
    parameter int DEBOUNCE_W = 8
);
    logic [N_CHANNELS-1:0]   trip_high;
    logic [N_CHANNELS-1:0]   trip_low;
    logic [N_CHANNELS-1:0]   channel_mask;
    logic [DEBOUNCE_W-1:0]   debounce_cycles;
    logic                    arm;
    logic                    fault_clear;
    logic                    clear_latch;
    logic                    fault;
    logic [2*N_CHANNELS-1:0] fault_source;
    logic [15:0]             fault_count;
    logic [2:0]              state;
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
    logic [7:0]              retry_count;
`endif

    // Controller side: drives comparator status and commands, observes fault outputs.
    modport master (
        output trip_high, trip_low, channel_mask, debounce_cycles, arm, fault_clear,
        input  clear_latch, fault, fault_source, fault_count, state
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
        , input retry_count
`endif
    );

    // Sequencer side.
    modport slave (
        input  trip_high, trip_low, channel_mask, debounce_cycles, arm, fault_clear,
        output clear_latch, fault, fault_source, fault_count, state
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
        , output retry_count
`endif
    );
endinterface

// File: rtl/comparator_fault_sequencer.sv
// Protection sequencer for a bank of threshold comparators: debounces the
// masked trip lines, raises a global fault, records the offending channels
// and runs the clear_latch handshake back to the comparators.
// Optional automatic retry: COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN.
module comparator_fault_sequencer #(
    parameter int N_CHANNELS    = 4,
    parameter int DEBOUNCE_W    = 8,
    parameter int CLEAR_PULSE   = 4,
    parameter int RETRY_HOLDOFF = 1000,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    comparator_fault_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_FAULT    = 3'd3,
        ST_CLEARING = 3'd4
    } state_t;

    localparam int CLR_W = $clog2(CLEAR_PULSE + 1);

    state_t                  state_q, state_d;
    logic [DEBOUNCE_W-1:0]   cnt_q, cnt_d;
    logic [CLR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic                    clear_latch_q, clear_latch_d;
    logic                    fault_q, fault_d;
    logic [2*N_CHANNELS-1:0] fault_source_q, fault_source_d;
    logic [15:0]             fault_count_q, fault_count_d;
    logic                    enter_fault;
    logic                    active;
    logic [2*N_CHANNELS-1:0] source_now;

`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
    localparam int HOLD_W = $clog2(RETRY_HOLDOFF + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        retry_q, retry_d;
`endif

    assign active     = |((bus.trip_high | bus.trip_low) & bus.channel_mask);
    assign source_now = {bus.trip_high & bus.channel_mask, bus.trip_low & bus.channel_mask};

    // Next-state and output decode; fault entry is handled once after the case.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        clr_cnt_d      = clr_cnt_q;
        fault_d        = fault_q;
        fault_source_d = fault_source_q;
        fault_count_d  = fault_count_q;
        enter_fault    = 1'b0;
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
        hold_d         = '0;
        retry_d        = retry_q;
`endif
        case (state_q)
            ST_DISARMED: begin
                fault_d = 1'b0;
                cnt_d   = '0;
                // Flush stale comparator latches before protection goes live.
                if (bus.arm) begin
                    state_d   = ST_CLEARING;
                    clr_cnt_d = '0;
                end
            end
            ST_ARMED: begin
                if (!bus.arm) begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end else if (active) begin
                    if (bus.debounce_cycles == '0) begin
                        enter_fault = 1'b1;
                    end else begin
                        state_d = ST_DEBOUNCE;
                        cnt_d   = DEBOUNCE_W'(1);
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (!bus.arm) begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end else if (!active) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else if (cnt_q == bus.debounce_cycles) begin
                    enter_fault = 1'b1;
                end else begin
                    cnt_d = cnt_q + DEBOUNCE_W'(1);
                end
            end
            ST_FAULT: begin
                if (bus.fault_clear) begin
                    state_d   = ST_CLEARING;
                    clr_cnt_d = '0;
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
                    retry_d   = '0;
                end else if (hold_q == HOLD_W'(RETRY_HOLDOFF - 1) &&
                             retry_q < 8'(MAX_RETRIES)) begin
                    state_d   = ST_CLEARING;
                    clr_cnt_d = '0;
                    retry_d   = retry_q + 8'd1;
                end else begin
                    // Saturate so an exhausted retry budget just waits for a manual clear.
                    hold_d = (hold_q == HOLD_W'(RETRY_HOLDOFF - 1)) ? hold_q : hold_q + HOLD_W'(1);
`endif
                end
            end
            ST_CLEARING: begin
                if (clr_cnt_q < CLR_W'(CLEAR_PULSE)) begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end else if (active) begin
                    enter_fault = 1'b1;
                end else if (bus.arm) begin
                    state_d = ST_ARMED;
                    fault_d = 1'b0;
                end else begin
                    state_d = ST_DISARMED;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_DISARMED;
                fault_d = 1'b0;
            end
        endcase

        if (enter_fault) begin
            state_d        = ST_FAULT;
            fault_d        = 1'b1;
            cnt_d          = '0;
            fault_source_d = source_now;
            fault_count_d  = (fault_count_q == 16'hFFFF) ? fault_count_q : fault_count_q + 16'd1;
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
            hold_d         = '0;
`endif
        end

        clear_latch_d = (state_d == ST_CLEARING) && (clr_cnt_d < CLR_W'(CLEAR_PULSE));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_DISARMED;
            cnt_q          <= '0;
            clr_cnt_q      <= '0;
            clear_latch_q  <= 1'b0;
            fault_q        <= 1'b0;
            fault_source_q <= '0;
            fault_count_q  <= '0;
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
            hold_q         <= '0;
            retry_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            clr_cnt_q      <= clr_cnt_d;
            clear_latch_q  <= clear_latch_d;
            fault_q        <= fault_d;
            fault_source_q <= fault_source_d;
            fault_count_q  <= fault_count_d;
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
            hold_q         <= hold_d;
            retry_q        <= retry_d;
`endif
        end
    end

    assign bus.clear_latch  = clear_latch_q;
    assign bus.fault        = fault_q;
    assign bus.fault_source = fault_source_q;
    assign bus.fault_count  = fault_count_q;
    assign bus.state        = state_q;
`ifdef COMPARATOR_FAULT_SEQUENCER_AUTO_RETRY_EN
    assign bus.retry_count  = retry_q;
`endif
endmodule
